// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipelined_barrel_shifter: O-stage valid/ready barrel shifter (SRL/SLL/SRA/ |
// | ROR); stage k shifts by 2**k. Macro PIPELINED_BARREL_SHIFTER_ROTATE_EN     |
// | enables rotate-right.                                  Rev 1.0             |
// +----------------------------------------------------------------------------+
module pipelined_barrel_shifter #(
  parameter int N = 32,
  parameter int O = $clog2(N),
  parameter int T = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [O-1:0] in_b,
  input  logic [1:0]   in_op,
  input  logic [T-1:0] in_tag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_c,
  output logic [T-1:0] out_tag,
  output logic         out_err
);

  localparam logic [1:0] c_op_srl = 2'b00;
  localparam logic [1:0] c_op_sll = 2'b01;
  localparam logic [1:0] c_op_sra = 2'b10;
  localparam logic [1:0] c_op_ror = 2'b11;

  function automatic logic [N-1:0] f_shift(input logic [N-1:0] d, input logic en,
                                           input logic [1:0] op, input int sh);
    logic [N-1:0] r;
    r = d;
    case (op)
      c_op_srl: if (en) r = d >> sh;
      c_op_sll: if (en) r = d << sh;
      c_op_sra: if (en) r = $signed(d) >>> sh;
      default: begin
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
        if (en) r = (d >> sh) | (d << (N - sh));
`else
        r = '0;
`endif
      end
    endcase
    return r;
  endfunction

  logic [O-1:0] r_valid;
  logic [O-1:0] r_err;
  logic [N-1:0] r_data [O];
  logic [O-1:0] r_amt  [O];
  logic [1:0]   r_op   [O];
  logic [T-1:0] r_tag  [O];

  logic [O-1:0] w_space;
  logic [O-1:0] w_v_in;
  logic [O-1:0] w_err_in;
  logic [N-1:0] w_d_in   [O];
  logic [O-1:0] w_amt_in [O];
  logic [1:0]   w_op_in  [O];
  logic [T-1:0] w_tag_in [O];
  logic [N-1:0] w_shift  [O];

  for (genvar k = 0; k < O; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_v_in[k]   = in_valid;
      assign w_d_in[k]   = in_a;
      assign w_amt_in[k] = in_b;
      assign w_op_in[k]  = in_op;
      assign w_tag_in[k] = in_tag;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
      assign w_err_in[k] = 1'b0;
`else
      assign w_err_in[k] = (in_op == c_op_ror);
`endif
    end else begin : g_body
      assign w_v_in[k]   = r_valid[k-1];
      assign w_d_in[k]   = r_data[k-1];
      assign w_amt_in[k] = r_amt[k-1];
      assign w_op_in[k]  = r_op[k-1];
      assign w_tag_in[k] = r_tag[k-1];
      assign w_err_in[k] = r_err[k-1];
    end
    // A stage may load when it, or any stage downstream of it, has a hole or the sink drains.
    assign w_space[k] = out_ready | ~(&r_valid[O-1:k]);
    assign w_shift[k] = f_shift(w_d_in[k], w_amt_in[k][0], w_op_in[k], 1 << k);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int k = 0; k < O; k++) begin
        r_data[k] <= '0;
        r_amt[k]  <= '0;
        r_op[k]   <= '0;
        r_tag[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < O; k++) begin
        if (w_space[k]) begin
          r_valid[k] <= w_v_in[k];
          // Payload only moves with a valid op so the output holds its last value across bubbles.
          if (w_v_in[k]) begin
            r_data[k] <= w_shift[k];
            r_amt[k]  <= w_amt_in[k] >> 1;
            r_op[k]   <= w_op_in[k];
            r_tag[k]  <= w_tag_in[k];
            r_err[k]  <= w_err_in[k];
          end
        end
      end
    end
  end

  assign in_ready  = rst_n & w_space[0];
  assign out_valid = r_valid[O-1];
  assign out_c     = r_data[O-1];
  assign out_tag   = r_tag[O-1];
  assign out_err   = r_err[O-1];

  logic w_unused;
  assign w_unused = ^{r_amt[O-1], r_op[O-1]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// Directed and randomized checks of pipelined_barrel_shifter at N=8, O=3, T=4.
module tb_pipelined_barrel_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [2:0] in_b;
  logic [1:0] in_op;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_c;
  logic [3:0] out_tag;
  logic       out_err;

  int n_tests = 0;
  int n_fail  = 0;

  pipelined_barrel_shifter #(.N(8), .O(3), .T(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [2:0] b,
                       input logic [1:0] op, input logic [3:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
  endtask

  // Issue one op with out_ready high and check it surfaces exactly three cycles later.
  task automatic run_one(input string name, input logic [7:0] a, input logic [2:0] b,
                         input logic [1:0] op, input logic [3:0] tag,
                         input logic [7:0] exp_c, input logic exp_err);
    drive(a, b, op, tag);
    tick();
    in_valid = 1'b0;
    check({name, "_lat1"}, out_valid, 1'b0);
    tick();
    check({name, "_lat2"}, out_valid, 1'b0);
    tick();
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_c"}, out_c, exp_c);
    check({name, "_tag"}, out_tag, tag);
    check({name, "_err"}, out_err, exp_err);
  endtask

  // Independent whole-word reference: returns {err, c}.
  function automatic logic [8:0] ref_op(input logic [7:0] a, input logic [2:0] b,
                                        input logic [1:0] op);
    logic [7:0] c;
    logic       e;
    e = 1'b0;
    case (op)
      2'b00: c = a >> b;
      2'b01: c = a << b;
      2'b10: c = $signed(a) >>> b;
      default: begin
        if (ROT) begin
          for (int i = 0; i < 8; i++) c[i] = a[(i + int'(b)) % 8];
        end else begin
          c = 8'h00;
          e = 1'b1;
        end
      end
    endcase
    return {e, c};
  endfunction

  logic [12:0] q[$];

  initial begin
    int sent;
    int got;
    int cyc;
    logic [8:0]  r;
    logic [12:0] e;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_c", out_c, 8'h00);
    check("rst_out_tag", out_tag, 4'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_in_ready_low", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_release", in_ready, 1'b1);

    // Single-op latency and content
    check("srl_in_ready", in_ready, 1'b1);
    run_one("srl", 8'hB4, 3'd3, 2'b00, 4'd5, 8'h16, 1'b0);
    tick();
    check("hold_valid_low", out_valid, 1'b0);
    check("hold_out_c", out_c, 8'h16);

    // Back-to-back SRA then SLL
    drive(8'hB4, 3'd2, 2'b10, 4'd1);
    tick();
    drive(8'h81, 3'd1, 2'b01, 4'd2);
    tick();
    in_valid = 1'b0;
    tick();
    check("b2b_sra_valid", out_valid, 1'b1);
    check("b2b_sra_c", out_c, 8'hED);
    check("b2b_sra_tag", out_tag, 4'd1);
    tick();
    check("b2b_sll_valid", out_valid, 1'b1);
    check("b2b_sll_c", out_c, 8'h02);
    check("b2b_sll_tag", out_tag, 4'd2);
    tick();
    check("b2b_drain", out_valid, 1'b0);

    // Rotate / compiled-out opcode, and shift-amount boundaries
    run_one("ror1", 8'h01, 3'd1, 2'b11, 4'd7, ROT ? 8'h80 : 8'h00, !ROT);
    run_one("ror7", 8'h01, 3'd7, 2'b11, 4'd8, ROT ? 8'h02 : 8'h00, !ROT);
    run_one("ror0", 8'hA5, 3'd0, 2'b11, 4'd9, ROT ? 8'hA5 : 8'h00, !ROT);
    run_one("sra0", 8'h5A, 3'd0, 2'b10, 4'd3, 8'h5A, 1'b0);
    run_one("sra7", 8'h80, 3'd7, 2'b10, 4'd4, 8'hFF, 1'b0);
    run_one("sll7", 8'h01, 3'd7, 2'b01, 4'd6, 8'h80, 1'b0);
    run_one("srl7", 8'h80, 3'd7, 2'b00, 4'd10, 8'h01, 1'b0);
    tick();

    // Backpressure: fill the pipe, hold, then release with a simultaneous accept
    out_ready = 1'b0;
    drive(8'h11, 3'd1, 2'b01, 4'd1);
    check("bp_ready0", in_ready, 1'b1);
    tick();
    drive(8'hF0, 3'd4, 2'b00, 4'd2);
    check("bp_ready1", in_ready, 1'b1);
    tick();
    drive(8'hF0, 3'd4, 2'b10, 4'd3);
    check("bp_ready2", in_ready, 1'b1);
    tick();
    drive(8'hC3, 3'd2, 2'b00, 4'd4);
    check("bp_full_ready", in_ready, 1'b0);
    check("bp_full_valid", out_valid, 1'b1);
    check("bp_full_c", out_c, 8'h22);
    tick();
    check("bp_hold_ready", in_ready, 1'b0);
    check("bp_hold_c", out_c, 8'h22);
    check("bp_hold_tag", out_tag, 4'd1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_r2_valid", out_valid, 1'b1);
    check("bp_r2", {out_tag, out_c}, {4'd2, 8'h0F});
    tick();
    check("bp_r3_valid", out_valid, 1'b1);
    check("bp_r3", {out_tag, out_c}, {4'd3, 8'hFF});
    tick();
    check("bp_r4_valid", out_valid, 1'b1);
    check("bp_r4", {out_tag, out_c}, {4'd4, 8'h30});
    tick();
    check("bp_drain", out_valid, 1'b0);

    // Reset with two ops in flight
    drive(8'h0F, 3'd1, 2'b01, 4'd11);
    tick();
    drive(8'hF0, 3'd2, 2'b00, 4'd12);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_c", out_c, 8'h00);
    for (int i = 0; i < 5; i++) begin
      check("mid_rst_no_stale", out_valid, 1'b0);
      tick();
    end

    // Random stream against the reference model
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 10000 && cyc < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      in_a      = 8'($urandom);
      in_b      = 3'($urandom);
      in_op     = 2'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        check("rand_nonempty", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rand_result", {out_err, out_tag, out_c}, e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        r = ref_op(in_a, in_b, in_op);
        q.push_back({r[8], in_tag, r[7:0]});
        sent++;
      end
      tick();
      cyc++;
    end
    check("rand_completed", got, 10000);
    check("rand_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter N, default 32: operand/result width in bits; SHALL be a power of two, N >= 2.
REQ-002 Parameter O, default $clog2(N): shift-amount width and number of pipeline stages.
REQ-003 Parameter T, default 4: width of the sideband tag carried alongside each operation.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst_n  input  1: synchronous, active-low reset.
REQ-006 in_valid  input  1: upstream presents an operation.
REQ-007 in_ready  output  1: block accepts the operation this cycle.
REQ-008 in_a  input  N: operand.
REQ-009 in_b  input  O: shift amount, 0..N-1.
REQ-010 in_op  input  2: 00 logical right, 01 logical left, 10 arithmetic right, 11 rotate right.
REQ-011 in_tag  input  T: sideband, returned unmodified with the result.
REQ-012 out_valid  output  1: result available.
REQ-013 out_ready  input  1: downstream consumes the result this cycle.
REQ-014 out_c  output  N: result.
REQ-015 out_tag  output  T: tag of the operation in out_c.
REQ-016 out_err  output  1: the operation used an opcode not compiled in.

Function
REQ-017 Transfer on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-018 O register stages; stage k (k = 0..O-1) applies shift by 2**k when bit in_b[k] is set; else passes through.
REQ-019 Each stage holds a valid bit, data, residual shift, op, tag and err; op and shift amount are carried to all later stages.
REQ-020 Stage k advances when stage k+1 is empty or advancing; last stage advances when out_ready is high; in_ready = stage-0 empty or stage-0 advancing.
REQ-021 Latency: an accepted operation appears on out_valid exactly O cycles later when out_ready is held high; throughput is 1 op/cycle.
REQ-022 While out_ready is low, out_c, out_tag and out_err SHALL stay stable and out_valid stays high until consumed; full pipe deasserts in_ready the same cycle.
REQ-023 Pipe full, out_ready rises: output consumed and new input accepted in that same cycle (no bubble).
REQ-024 Logical shifts fill vacated bits with 0; arithmetic right fills with in_a[N-1]; rotate right wraps bits from LSB to MSB.
REQ-025 in_b = 0 returns in_a unchanged for every op; results beyond N-1 are impossible since in_b is O bits wide.
REQ-026 Results are order-preserving; no operation is dropped or duplicated under any backpressure pattern.
REQ-027 in_a, in_b, in_op and in_tag are ignored when in_valid is low; out_c/out_tag are don't-care when out_valid is low but held at their last value.

Reset
REQ-028 rst_n low at a rising edge clears all stage valid bits, data, tags and err to 0; out_valid = 0, out_c = 0, out_tag = 0, out_err = 0.
REQ-029 in_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.
REQ-030 Reset mid-operation discards all in-flight operations; none appear on the output after release.

Configuration
REQ-031 Macro PIPELINED_BARREL_SHIFTER_ROTATE_EN defined: op 11 performs rotate right; out_err is always 0.
REQ-032 Macro undefined: rotate logic is absent; op 11 yields out_c = 0 with out_err = 1, same latency and handshake; other ops unchanged.

Verification (N=8, O=3, T=4)
REQ-033 SRL: a=8'hB4, b=3, op=00, tag=5, out_ready=1 -> 3 cycles later out_c=8'h16, out_tag=5, out_err=0.
REQ-034 SRA and SLL back-to-back: a=8'hB4,b=2,op=10 then a=8'h81,b=1,op=01 -> consecutive cycles out_c=8'hED then 8'h02.
REQ-035 ROR: a=8'h01, b=1, op=11 -> macro on: out_c=8'h80, out_err=0; macro off: out_c=8'h00, out_err=1.
REQ-036 Backpressure: out_ready=0, issue 4 ops with in_valid held -> in_ready falls after 3 accepts; out_c stable; raise out_ready -> 4 results in order, one per cycle, no bubble.
REQ-037 Reset mid-flight: 2 ops accepted, rst_n low one cycle -> out_valid=0 thereafter, no stale results; in_ready=1 the first cycle after release.
REQ-038 Random stream of 10,000 ops with random in_valid/out_ready against a reference model -> all results and tags match, in order.
